// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file and its read ports.
// The register count, tag width and the hardwired-zero register index are defined only here.
package register_file_pkg;

    localparam int RoB_WIDTH  = 3;
    localparam int REG_COUNT  = 32;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // True when the addressed register can hold state (x0 is wired to zero).
    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational operand port: masks x0 to zero and lets a matching commit
// bypass the stored value so the dispatcher sees the result in the same cycle.
module reg_read_port
    import register_file_pkg::*;
#(
    parameter int TAG_W = RoB_WIDTH
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       stored_val,
    input  logic                  stored_busy,
    input  logic [TAG_W-1:0]      stored_tag,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_reg,
    input  logic [TAG_W-1:0]      commit_index,
    input  logic [XLEN-1:0]       commit_data,
    output logic [XLEN-1:0]       val,
    output logic                  busy,
    output logic [TAG_W-1:0]      tag
);

    logic bypass_hit;

    // Forward only when the commit retires the producer this register is waiting on.
    assign bypass_hit = commit_valid
                     && (commit_reg == addr)
                     && stored_busy
                     && (stored_tag == commit_index);

    always_comb begin
        val  = stored_val;
        busy = stored_busy;
        tag  = stored_tag;
        if (!is_real_reg(addr)) begin
            val  = '0;
            busy = 1'b0;
            tag  = '0;
        end else if (bypass_hit) begin
            val  = commit_data;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and rename tag,
// written by RoB commits and renamed by the dispatcher, one of each per cycle.
module register_file
    import register_file_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  commit_en,
    input  logic [REG_ADDR_W-1:0] commit_reg,
    input  logic [RoB_WIDTH-1:0]  commit_index,
    input  logic [XLEN-1:0]       commit_data,
    input  logic                  rename_en,
    input  logic [REG_ADDR_W-1:0] rename_rd,
    input  logic [RoB_WIDTH-1:0]  rename_index,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [RoB_WIDTH-1:0]  rs1_tag,
    output logic [RoB_WIDTH-1:0]  rs2_tag,
    output logic [XLEN-1:0]       rs1_val,
    output logic [XLEN-1:0]       rs2_val
);

    logic [XLEN-1:0]      value [REG_COUNT];
    logic [RoB_WIDTH-1:0] tag   [REG_COUNT];
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;

    logic commit_act;
    logic rename_act;
    logic commit_match;
    logic commit_valid;

    assign commit_valid = rdy_in && commit_en;
    assign commit_act   = commit_valid && is_real_reg(commit_reg);
    assign rename_act   = rdy_in && rename_en && is_real_reg(rename_rd) && !flush_in;
    assign commit_match = commit_act && busy[commit_reg] && (tag[commit_reg] == commit_index);

    // A same-cycle rename of the committing register keeps it busy for the new producer.
    always_comb begin
        busy_next = busy;
        if (rdy_in && flush_in) begin
            busy_next = '0;
        end else begin
            if (commit_match && !(rename_act && (rename_rd == commit_reg))) begin
                busy_next[commit_reg] = 1'b0;
            end
            if (rename_act) begin
                busy_next[rename_rd] = 1'b1;
            end
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            busy <= busy_next;
            if (commit_act) begin
                value[commit_reg] <= commit_data;
            end
            if (rename_act) begin
                tag[rename_rd] <= rename_index;
            end
        end
    end

    reg_read_port #(.TAG_W(RoB_WIDTH)) u_rs1_port (
        .addr         (rs1_addr),
        .stored_val   (value[rs1_addr]),
        .stored_busy  (busy[rs1_addr]),
        .stored_tag   (tag[rs1_addr]),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_index (commit_index),
        .commit_data  (commit_data),
        .val          (rs1_val),
        .busy         (rs1_busy),
        .tag          (rs1_tag)
    );

    reg_read_port #(.TAG_W(RoB_WIDTH)) u_rs2_port (
        .addr         (rs2_addr),
        .stored_val   (value[rs2_addr]),
        .stored_busy  (busy[rs2_addr]),
        .stored_tag   (tag[rs2_addr]),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_index (commit_index),
        .commit_data  (commit_data),
        .val          (rs2_val),
        .busy         (rs2_busy),
        .tag          (rs2_tag)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: each row drives one cycle of
// inputs and states the combinational read results expected before that edge.
module tb_register_file;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [2:0]  commit_index;
    logic [31:0] commit_data;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [2:0]  rename_index;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [2:0]  rs1_tag;
    logic [2:0]  rs2_tag;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    int checks;
    int passes;

    register_file dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .commit_en    (commit_en),
        .commit_reg   (commit_reg),
        .commit_index (commit_index),
        .commit_data  (commit_data),
        .rename_en    (rename_en),
        .rename_rd    (rename_rd),
        .rename_index (rename_index),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        flush;
        logic        c_en;
        logic [4:0]  c_reg;
        logic [2:0]  c_idx;
        logic [31:0] c_data;
        logic        r_en;
        logic [4:0]  r_rd;
        logic [2:0]  r_idx;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        b1;
        logic [2:0]  t1;
        logic [31:0] v1;
        logic        b2;
        logic [2:0]  t2;
        logic [31:0] v2;
    } vec_t;

    vec_t vecs [18];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rdy_in       = v.rdy;
        flush_in     = v.flush;
        commit_en    = v.c_en;
        commit_reg   = v.c_reg;
        commit_index = v.c_idx;
        commit_data  = v.c_data;
        rename_en    = v.r_en;
        rename_rd    = v.r_rd;
        rename_index = v.r_idx;
        rs1_addr     = v.a1;
        rs2_addr     = v.a2;
    endtask

    task automatic idleInputs();
        rdy_in       = 1'b1;
        flush_in     = 1'b0;
        commit_en    = 1'b0;
        commit_reg   = '0;
        commit_index = '0;
        commit_data  = '0;
        rename_en    = 1'b0;
        rename_rd    = '0;
        rename_index = '0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_in = 1'b1;
        idleInputs();
        rs1_addr = '0;
        rs2_addr = '0;

        //           rdy fl cen creg cidx cdata          ren rrd ridx a1  a2   b1 t1 v1             b2 t2 v2
        vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 5, 0,  0, 0, 32'h0,         0, 0, 32'h0};
        vecs[1]  = '{1, 0, 0, 0, 0, 32'h0,         1, 3, 2, 3, 3,  0, 0, 32'h0,         0, 0, 32'h0};
        vecs[2]  = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 3, 5,  1, 2, 32'h0,         0, 0, 32'h0};
        vecs[3]  = '{1, 0, 1, 3, 2, 32'hDEAD,      0, 0, 0, 3, 5,  0, 0, 32'hDEAD,      0, 0, 32'h0};
        vecs[4]  = '{1, 0, 0, 0, 0, 32'h0,         1, 4, 1, 3, 0,  0, 0, 32'hDEAD,      0, 0, 32'h0};
        vecs[5]  = '{1, 0, 0, 0, 0, 32'h0,         1, 4, 5, 4, 3,  1, 1, 32'h0,         0, 0, 32'hDEAD};
        vecs[6]  = '{1, 0, 1, 4, 1, 32'h11,        0, 0, 0, 4, 0,  1, 5, 32'h0,         0, 0, 32'h0};
        vecs[7]  = '{1, 0, 0, 0, 0, 32'h0,         1, 6, 3, 4, 0,  1, 5, 32'h11,        0, 0, 32'h0};
        vecs[8]  = '{1, 0, 1, 6, 3, 32'h66,        1, 6, 7, 6, 4,  0, 0, 32'h66,        1, 5, 32'h11};
        vecs[9]  = '{1, 0, 0, 0, 0, 32'h0,         1, 1, 1, 6, 0,  1, 7, 32'h66,        0, 0, 32'h0};
        vecs[10] = '{1, 0, 0, 0, 0, 32'h0,         1, 2, 4, 1, 6,  1, 1, 32'h0,         1, 7, 32'h66};
        vecs[11] = '{1, 1, 1, 5, 0, 32'h55,        1, 7, 6, 2, 1,  1, 4, 32'h0,         1, 1, 32'h0};
        vecs[12] = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 2,  0, 0, 32'h0,         0, 0, 32'h0};
        vecs[13] = '{1, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 3, 0, 7,  0, 0, 32'h0,         0, 0, 32'h0};
        vecs[14] = '{0, 0, 1, 8, 0, 32'h88,        0, 0, 0, 0, 6,  0, 0, 32'h0,         0, 0, 32'h66};
        vecs[15] = '{0, 0, 0, 0, 0, 32'h0,         1, 9, 2, 8, 5,  0, 0, 32'h0,         0, 0, 32'h55};
        vecs[16] = '{1, 0, 1, 8, 0, 32'h88,        0, 0, 0, 9, 8,  0, 0, 32'h0,         0, 0, 32'h0};
        vecs[17] = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 8, 0,  0, 0, 32'h88,        0, 0, 32'h0};

        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("v%0d rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vecs[i].b1});
            checkOutput($sformatf("v%0d rs1_val", i), rs1_val, vecs[i].v1);
            if (vecs[i].b1) checkOutput($sformatf("v%0d rs1_tag", i), {29'b0, rs1_tag}, {29'b0, vecs[i].t1});
            checkOutput($sformatf("v%0d rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vecs[i].b2});
            checkOutput($sformatf("v%0d rs2_val", i), rs2_val, vecs[i].v2);
            if (vecs[i].b2) checkOutput($sformatf("v%0d rs2_tag", i), {29'b0, rs2_tag}, {29'b0, vecs[i].t2});
            @(negedge clk_in);
        end

        // Async reset mid-cycle with x3 busy: must clear without a clock edge.
        idleInputs();
        rename_en    = 1'b1;
        rename_rd    = 5'd3;
        rename_index = 3'd5;
        @(negedge clk_in);
        idleInputs();
        rs1_addr = 5'd3;
        rs2_addr = 5'd8;
        #1;
        checkOutput("pre_reset x3 busy", {31'b0, rs1_busy}, 32'd1);
        checkOutput("pre_reset x3 tag", {29'b0, rs1_tag}, 32'd5);
        checkOutput("pre_reset x8 val", rs2_val, 32'h88);
        rst_in = 1'b1;
        #1;
        checkOutput("async_reset x3 busy", {31'b0, rs1_busy}, 32'd0);
        checkOutput("async_reset x3 val", rs1_val, 32'h0);
        checkOutput("async_reset x8 val", rs2_val, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checkOutput("post_reset x3 busy", {31'b0, rs1_busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
